// File: rtl/riscv_mt_pkg.sv
// Shared types and helpers for the 4-thread fine-grained multithreaded core.
package riscv_mt_pkg;

   localparam int NUM_THREADS = 4;
   localparam int TID_W       = $clog2(NUM_THREADS);

   typedef enum logic [1:0] {
      TS_IDLE    = 2'b00,
      TS_RUN     = 2'b01,
      TS_BLOCKED = 2'b10
   } thread_state_e;

   // One-hot of the first set mask bit strictly after i_last, wrapping around.
   function automatic logic [NUM_THREADS-1:0] rr_pick(
      input logic [NUM_THREADS-1:0] i_mask,
      input logic [TID_W-1:0]       i_last
   );
      logic [NUM_THREADS-1:0] w_onehot;
      logic                   w_found;
      logic [TID_W-1:0]       w_idx;
      w_onehot = '0;
      w_found  = 1'b0;
      for (int k = 1; k <= NUM_THREADS; k++) begin
         w_idx = TID_W'((int'(i_last) + k) % NUM_THREADS);
         if (!w_found && i_mask[w_idx]) begin
            w_onehot[w_idx] = 1'b1;
            w_found         = 1'b1;
         end
      end
      return w_onehot;
   endfunction

endpackage

// File: rtl/thread_ctx.sv
// Per-thread lifecycle FSM (idle/run/blocked) plus re-issue cooldown counter.
module thread_ctx
   import riscv_mt_pkg::*;
#(
   parameter int MIN_GAP = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_start,
   input  logic       i_halt,
   input  logic       i_block,
   input  logic       i_wake,
   input  logic       i_issued,
   input  logic       i_advance,
   output logic [1:0] o_state,
   output logic       o_eligible
);

   thread_state_e r_state;
   thread_state_e w_state_nxt;
   logic          w_cd_zero;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= TS_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Priority halt > start > wake > block; start outside IDLE falls through.
   always_comb begin
      w_state_nxt = r_state;
      if (i_halt)
         w_state_nxt = TS_IDLE;
      else if (i_start && (r_state == TS_IDLE))
         w_state_nxt = TS_RUN;
      else if ((r_state == TS_BLOCKED) && i_wake)
         w_state_nxt = TS_RUN;
      else if ((r_state == TS_RUN) && i_block && !i_wake)
         w_state_nxt = TS_BLOCKED;
   end

   generate
      if (MIN_GAP > 0) begin : g_cooldown
         localparam int CW = $clog2(MIN_GAP + 1);
         logic [CW-1:0] r_cd;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               r_cd <= '0;
            else if (i_advance) begin
               if (i_issued)           r_cd <= CW'(MIN_GAP);
               else if (r_cd != '0)    r_cd <= r_cd - 1'b1;
            end
         end

         assign w_cd_zero = (r_cd == '0);
      end else begin : g_no_cooldown
         assign w_cd_zero = 1'b1;
      end
   endgenerate

   assign o_state    = r_state;
   assign o_eligible = (r_state == TS_RUN) && !i_block && !i_halt && w_cd_zero;

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin issue scheduler with tag delay line feeding ID and WB bank selects.
module thread_scheduler
   import riscv_mt_pkg::*;
#(
   parameter int MIN_GAP = 3,
   parameter int ID_LAT  = 1,
   parameter int WB_LAT  = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     stall,
   input  logic [NUM_THREADS-1:0]   thread_start,
   input  logic [NUM_THREADS-1:0]   thread_halt,
   input  logic [NUM_THREADS-1:0]   thread_block,
   input  logic [NUM_THREADS-1:0]   thread_wake,
   output logic                     issue_valid,
   output logic [NUM_THREADS-1:0]   thread_sel_IF,
   output logic [NUM_THREADS-1:0]   thread_sel_ID,
   output logic [NUM_THREADS-1:0]   thread_sel_WB,
   output logic [2*NUM_THREADS-1:0] thread_state
);

   logic                   w_advance;
   logic [NUM_THREADS-1:0] w_elig;
   logic [NUM_THREADS-1:0] w_pick;
   logic [TID_W-1:0]       w_win_idx;

   logic                   r_valid;
   logic [NUM_THREADS-1:0] r_sel_if;
   logic [TID_W-1:0]       r_last;
   logic [NUM_THREADS-1:0] r_dly [WB_LAT];

   assign w_advance = !stall;

   generate
      for (genvar i = 0; i < NUM_THREADS; i++) begin : g_ctx
         thread_ctx #(
            .MIN_GAP (MIN_GAP)
         ) u_ctx (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_start    (thread_start[i]),
            .i_halt     (thread_halt[i]),
            .i_block    (thread_block[i]),
            .i_wake     (thread_wake[i]),
            .i_issued   (w_pick[i]),
            .i_advance  (w_advance),
            .o_state    (thread_state[2*i +: 2]),
            .o_eligible (w_elig[i])
         );
      end
   endgenerate

   assign w_pick = rr_pick(w_elig, r_last);

   always_comb begin
      w_win_idx = r_last;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (w_pick[i]) w_win_idx = TID_W'(i);
      end
   end

   // Issue register, pointer and delay line all freeze together under stall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid  <= 1'b0;
         r_sel_if <= '0;
         r_last   <= TID_W'(NUM_THREADS - 1);
         for (int k = 0; k < WB_LAT; k++) r_dly[k] <= '0;
      end else if (w_advance) begin
         r_valid  <= |w_pick;
         r_sel_if <= w_pick;
         if (|w_pick) r_last <= w_win_idx;
         r_dly[0] <= r_sel_if;
         for (int k = 1; k < WB_LAT; k++) r_dly[k] <= r_dly[k-1];
      end
   end

   generate
      if (ID_LAT == 0) begin : g_id_direct
         assign thread_sel_ID = r_sel_if;
      end else begin : g_id_tap
         assign thread_sel_ID = r_dly[ID_LAT-1];
      end
   endgenerate

   assign issue_valid   = r_valid;
   assign thread_sel_IF = r_sel_if;
   assign thread_sel_WB = r_dly[WB_LAT-1];

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: round-robin order, cooldown, block/wake, stall, halt, reset.
module tb_thread_scheduler;

   logic       clk;
   logic       reset_n;
   logic       stall;
   logic [3:0] start, halt, block, wake;

   logic       valid,  valid0;
   logic [3:0] sel_if, sel_id, sel_wb;
   logic [3:0] sel_if0, sel_id0, sel_wb0;
   logic [7:0] state,  state0;

   int n_cmp = 0;
   int n_err = 0;
   int step_no = 0;
   logic [3:0] hist [0:4];

   thread_scheduler #(.MIN_GAP(3), .ID_LAT(1), .WB_LAT(4)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall         (stall),
      .thread_start  (start),
      .thread_halt   (halt),
      .thread_block  (block),
      .thread_wake   (wake),
      .issue_valid   (valid),
      .thread_sel_IF (sel_if),
      .thread_sel_ID (sel_id),
      .thread_sel_WB (sel_wb),
      .thread_state  (state)
   );

   thread_scheduler #(.MIN_GAP(0), .ID_LAT(1), .WB_LAT(4)) u_dut0 (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall         (stall),
      .thread_start  (start),
      .thread_halt   (halt),
      .thread_block  (block),
      .thread_wake   (wake),
      .issue_valid   (valid0),
      .thread_sel_IF (sel_if0),
      .thread_sel_ID (sel_id0),
      .thread_sel_WB (sel_wb0),
      .thread_state  (state0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
      end
   endtask

   task automatic clear_hist();
      for (int k = 0; k < 5; k++) hist[k] = 4'b0000;
   endtask

   // One clock; adv=1 means the pipeline advanced and exp_if is the new IF tag.
   task automatic step_chk(input logic [3:0] exp_if, input bit adv);
      @(posedge clk);
      #1;
      step_no++;
      if (adv) begin
         for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = exp_if;
      end
      chk("sel_IF", {4'b0, sel_if}, {4'b0, exp_if});
      chk("issue_valid", {7'b0, valid}, {7'b0, |exp_if});
      chk("sel_ID", {4'b0, sel_id}, {4'b0, hist[1]});
      chk("sel_WB", {4'b0, sel_wb}, {4'b0, hist[4]});
   endtask

   task automatic chk0(input logic [3:0] exp_if);
      chk("gap0_sel_IF", {4'b0, sel_if0}, {4'b0, exp_if});
   endtask

   initial begin
      reset_n = 1'b0;
      stall   = 1'b0;
      start   = 4'b0000;
      halt    = 4'b0000;
      block   = 4'b0000;
      wake    = 4'b0000;
      clear_hist();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_IF", {4'b0, sel_if}, 8'h00);
      chk("rst_valid", {7'b0, valid}, 8'h00);
      chk("rst_ID", {4'b0, sel_id}, 8'h00);
      chk("rst_WB", {4'b0, sel_wb}, 8'h00);
      chk("rst_state", state, 8'h00);

      // All four threads started: rotation with no bubbles.
      reset_n = 1'b1;
      start   = 4'b1111;
      step_chk(4'b0000, 1);
      start   = 4'b0000;
      chk("state_all_run", state, 8'h55);
      step_chk(4'b0001, 1);
      step_chk(4'b0010, 1);
      step_chk(4'b0100, 1);
      step_chk(4'b1000, 1);
      step_chk(4'b0001, 1);
      step_chk(4'b0010, 1);
      step_chk(4'b0100, 1);
      step_chk(4'b1000, 1);

      // Block thread 1: three threads under gap 3 leave one bubble per round.
      block = 4'b0010;
      step_chk(4'b0001, 1);
      block = 4'b0000;
      chk("state_t1_blocked", state, 8'h59);
      step_chk(4'b0000, 1);
      step_chk(4'b0100, 1);
      step_chk(4'b1000, 1);
      step_chk(4'b0001, 1);
      step_chk(4'b0000, 1);

      // Wake thread 1: it rejoins in round-robin order.
      wake = 4'b0010;
      step_chk(4'b0100, 1);
      wake = 4'b0000;
      step_chk(4'b1000, 1);
      step_chk(4'b0001, 1);
      step_chk(4'b0010, 1);
      step_chk(4'b0100, 1);
      step_chk(4'b1000, 1);

      // Block and wake together on a running thread: it stays RUN.
      block = 4'b0010;
      wake  = 4'b0010;
      step_chk(4'b0001, 1);
      block = 4'b0000;
      wake  = 4'b0000;
      chk("state_blk_wake", state, 8'h55);
      step_chk(4'b0010, 1);
      step_chk(4'b0100, 1);
      step_chk(4'b1000, 1);

      // Three stalled cycles freeze every select; resume where it stopped.
      stall = 1'b1;
      step_chk(4'b1000, 0);
      step_chk(4'b1000, 0);
      step_chk(4'b1000, 0);
      stall = 1'b0;
      step_chk(4'b0001, 1);
      step_chk(4'b0010, 1);
      step_chk(4'b0100, 1);

      // Halt and start together on thread 0: it goes IDLE and never issues.
      halt  = 4'b0001;
      start = 4'b0001;
      step_chk(4'b1000, 1);
      halt  = 4'b0000;
      start = 4'b0000;
      chk("state_t0_halted", state, 8'h54);
      step_chk(4'b0000, 1);
      step_chk(4'b0010, 1);
      step_chk(4'b0100, 1);
      step_chk(4'b1000, 1);
      step_chk(4'b0000, 1);
      step_chk(4'b0010, 1);

      // Asynchronous reset between edges clears outputs without a clock.
      #2;
      reset_n = 1'b0;
      #2;
      chk("arst_IF", {4'b0, sel_if}, 8'h00);
      chk("arst_valid", {7'b0, valid}, 8'h00);
      chk("arst_ID", {4'b0, sel_id}, 8'h00);
      chk("arst_WB", {4'b0, sel_wb}, 8'h00);
      chk("arst_state", state, 8'h00);
      chk("arst_gap0_IF", {4'b0, sel_if0}, 8'h00);
      clear_hist();
      @(posedge clk);
      #1;

      // After release, thread 0 wins first; then only thread 2 remains.
      reset_n = 1'b1;
      start   = 4'b1111;
      step_chk(4'b0000, 1);
      chk0(4'b0000);
      start   = 4'b0000;
      step_chk(4'b0001, 1);
      chk0(4'b0001);
      halt    = 4'b1011;
      step_chk(4'b0100, 1);
      chk0(4'b0100);
      halt    = 4'b0000;
      chk("state_t2_only", state, 8'h10);
      step_chk(4'b0000, 1);
      chk0(4'b0100);
      step_chk(4'b0000, 1);
      chk0(4'b0100);
      step_chk(4'b0000, 1);
      chk0(4'b0100);
      step_chk(4'b0100, 1);
      chk0(4'b0100);
      step_chk(4'b0000, 1);
      chk0(4'b0100);
      step_chk(4'b0000, 1);
      step_chk(4'b0000, 1);
      step_chk(4'b0100, 1);
      chk0(4'b0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
